// File: rtl/hit_storage_pkg.sv
// Shared widths, HCM field positions and reader state encoding for the hit storage
// writer/reader pair.
package hit_storage_pkg;

    localparam int SSID_BITS      = 10;
    localparam int COL_INDEX_BITS = 5;
    localparam int HIT_INFO_BITS  = 8;
    localparam int MAX_HITS       = 4;
    localparam int HIM_ADDR_BITS  = 8;
    localparam int HIT_COUNT_BITS = 3;

    localparam int NCOLS_HNM     = 2 ** COL_INDEX_BITS;
    localparam int HNM_ROW_BITS  = SSID_BITS - COL_INDEX_BITS;
    localparam int HCM_WORD_BITS = HIM_ADDR_BITS + HIT_COUNT_BITS;
    localparam int HIM_WORD_BITS = MAX_HITS * HIT_INFO_BITS;
    localparam int SLOT_BITS     = (MAX_HITS > 1) ? $clog2(MAX_HITS) : 1;

    // HCM word layout: {him_addr, hit_count}
    localparam int HCM_COUNT_LSB = 0;
    localparam int HCM_COUNT_MSB = HCM_COUNT_LSB + HIT_COUNT_BITS - 1;
    localparam int HCM_ADDR_LSB  = HIT_COUNT_BITS;
    localparam int HCM_ADDR_MSB  = HCM_WORD_BITS - 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_A   = 3'd1,
        ST_CHECK    = 3'd2,
        ST_WAIT_HIM = 3'd3,
        ST_LOAD_HIM = 3'd4,
        ST_STREAM   = 3'd5
    } reader_state_e;

    function automatic logic [HIT_INFO_BITS-1:0] slot_word(
        input logic [HIM_WORD_BITS-1:0] row,
        input logic [SLOT_BITS-1:0]     idx
    );
        return row[int'(idx)*HIT_INFO_BITS +: HIT_INFO_BITS];
    endfunction

endpackage

// File: rtl/hit_retrieval_reader_unpacker.sv
// Serialises one HIM row, oldest slot (n-1) first down to slot 0, over valid/ready.
module hit_row_unpacker
    import hit_storage_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      load,
    input  logic [HIM_WORD_BITS-1:0]  load_row,
    input  logic [HIT_COUNT_BITS-1:0] load_count,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [HIT_INFO_BITS-1:0]  out_hit_info,
    output logic                      out_last
);

    logic [HIM_WORD_BITS-1:0] row_r;
    logic [SLOT_BITS-1:0]     slot_r;
    logic [SLOT_BITS-1:0]     first_slot_s;
    logic [SLOT_BITS-1:0]     next_slot_s;
    logic [HIT_INFO_BITS-1:0] info_r;
    logic                     valid_r;
    logic                     last_r;

    // load_count is never 0 here; the reader treats a zero count as a miss
    assign first_slot_s = SLOT_BITS'(load_count - HIT_COUNT_BITS'(1));
    assign next_slot_s  = slot_r - SLOT_BITS'(1);

    // Row/slot register: load points at the oldest slot, each handshake steps toward slot 0
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            row_r   <= {HIM_WORD_BITS{1'b0}};
            slot_r  <= {SLOT_BITS{1'b0}};
            info_r  <= {HIT_INFO_BITS{1'b0}};
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end else if (load) begin
            row_r   <= load_row;
            slot_r  <= first_slot_s;
            info_r  <= slot_word(load_row, first_slot_s);
            valid_r <= 1'b1;
            last_r  <= (load_count == HIT_COUNT_BITS'(1));
        end else if (valid_r && out_ready) begin
            if (last_r) begin
                valid_r <= 1'b0;
                last_r  <= 1'b0;
            end else begin
                slot_r  <= next_slot_s;
                info_r  <= slot_word(row_r, next_slot_s);
                last_r  <= (slot_r == SLOT_BITS'(1));
            end
        end
    end

    assign out_valid    = valid_r;
    assign out_hit_info = info_r;
    assign out_last     = last_r;

endmodule

// File: rtl/hit_retrieval_reader.sv
// Looks up a query SSID in HNM, then HCM and HIM, and streams the stored hit-info
// words oldest-first to track fitting.
module hit_retrieval_reader
    import hit_storage_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      clear_memory,
    input  logic                      storage_ready,
    input  logic                      query_valid,
    output logic                      query_ready,
    input  logic [SSID_BITS-1:0]      query_ssid,
    output logic [HNM_ROW_BITS-1:0]   hnm_addr,
    input  logic [NCOLS_HNM-1:0]      hnm_rd_data,
    output logic [SSID_BITS-1:0]      hcm_addr,
    input  logic [HCM_WORD_BITS-1:0]  hcm_rd_data,
    output logic [HIM_ADDR_BITS-1:0]  him_addr,
    input  logic [HIM_WORD_BITS-1:0]  him_rd_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [HIT_INFO_BITS-1:0]  out_hit_info,
    output logic                      out_last,
    output logic                      query_done,
    output logic [HIT_COUNT_BITS-1:0] query_count,
    output logic                      query_overflow,
    output logic                      query_aborted
);

    reader_state_e state_r, state_next_s;

    logic [COL_INDEX_BITS-1:0] col_r, col_next_s;
    logic [HNM_ROW_BITS-1:0]   hnm_addr_r, hnm_addr_next_s;
    logic [SSID_BITS-1:0]      hcm_addr_r, hcm_addr_next_s;
    logic [HIM_ADDR_BITS-1:0]  him_addr_r, him_addr_next_s;
    logic [HIT_COUNT_BITS-1:0] count_r, count_next_s;
    logic [HIT_COUNT_BITS-1:0] done_count_r, done_count_next_s;
    logic done_r, done_next_s, aborted_r, aborted_next_s, overflow_r, overflow_next_s;

    logic [HIT_COUNT_BITS-1:0] hcm_count_s, load_n_s;
    logic [HIM_ADDR_BITS-1:0]  hcm_him_addr_s;
    logic idle_s, accept_s, abort_s, hit_s, load_s, flush_s, last_fire_s;
    logic beat_valid_s, beat_last_s;

    assign idle_s         = (state_r == ST_IDLE);
    assign query_ready    = idle_s & storage_ready & ~clear_memory;
    assign accept_s       = query_ready & query_valid;
    assign abort_s        = ~idle_s & clear_memory;
    assign hcm_count_s    = hcm_rd_data[HCM_COUNT_MSB:HCM_COUNT_LSB];
    assign hcm_him_addr_s = hcm_rd_data[HCM_ADDR_MSB:HCM_ADDR_LSB];
    // A set HNM bit with a zero count carries nothing to stream
    assign hit_s          = hnm_rd_data[col_r] & (hcm_count_s != {HIT_COUNT_BITS{1'b0}});
    assign load_n_s       = (count_r > HIT_COUNT_BITS'(MAX_HITS)) ? HIT_COUNT_BITS'(MAX_HITS) : count_r;
    assign last_fire_s    = beat_valid_s & out_ready & beat_last_s;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; clear_memory overrides every non-idle transition
    always_comb begin
        state_next_s = state_r;
        if (abort_s) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:     state_next_s = accept_s ? ST_WAIT_A : ST_IDLE;
                ST_WAIT_A:   state_next_s = ST_CHECK;
                ST_CHECK:    state_next_s = hit_s ? ST_WAIT_HIM : ST_IDLE;
                ST_WAIT_HIM: state_next_s = ST_LOAD_HIM;
                ST_LOAD_HIM: state_next_s = ST_STREAM;
                ST_STREAM:   state_next_s = last_fire_s ? ST_IDLE : ST_STREAM;
                default:     state_next_s = ST_IDLE;
            endcase
        end
    end

    // Next values of the registered outputs and datapath registers
    always_comb begin
        col_next_s        = col_r;
        hnm_addr_next_s   = hnm_addr_r;
        hcm_addr_next_s   = hcm_addr_r;
        him_addr_next_s   = him_addr_r;
        count_next_s      = count_r;
        done_next_s       = 1'b0;
        done_count_next_s = {HIT_COUNT_BITS{1'b0}};
        aborted_next_s    = 1'b0;
        overflow_next_s   = 1'b0;
        load_s            = 1'b0;
        flush_s           = 1'b0;
        if (abort_s) begin
            done_next_s    = 1'b1;
            aborted_next_s = 1'b1;
            flush_s        = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        col_next_s      = query_ssid[COL_INDEX_BITS-1:0];
                        hnm_addr_next_s = query_ssid[SSID_BITS-1:COL_INDEX_BITS];
                        hcm_addr_next_s = query_ssid;
                    end else begin
                        col_next_s = col_r;
                    end
                end
                ST_CHECK: begin
                    if (hit_s) begin
                        count_next_s    = hcm_count_s;
                        him_addr_next_s = hcm_him_addr_s;
                    end else begin
                        done_next_s = 1'b1;
                    end
                end
                ST_LOAD_HIM: begin
                    load_s          = 1'b1;
                    overflow_next_s = (count_r > HIT_COUNT_BITS'(MAX_HITS));
                end
                ST_STREAM: begin
                    if (last_fire_s) begin
                        done_next_s       = 1'b1;
                        done_count_next_s = count_r;
                    end else begin
                        done_next_s = 1'b0;
                    end
                end
                default: begin
                    done_next_s = 1'b0;
                end
            endcase
        end
    end

    // Datapath and status registers
    always_ff @(posedge clock) begin
        if (reset) begin
            col_r        <= {COL_INDEX_BITS{1'b0}};
            hnm_addr_r   <= {HNM_ROW_BITS{1'b0}};
            hcm_addr_r   <= {SSID_BITS{1'b0}};
            him_addr_r   <= {HIM_ADDR_BITS{1'b0}};
            count_r      <= {HIT_COUNT_BITS{1'b0}};
            done_r       <= 1'b0;
            done_count_r <= {HIT_COUNT_BITS{1'b0}};
            aborted_r    <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            col_r        <= col_next_s;
            hnm_addr_r   <= hnm_addr_next_s;
            hcm_addr_r   <= hcm_addr_next_s;
            him_addr_r   <= him_addr_next_s;
            count_r      <= count_next_s;
            done_r       <= done_next_s;
            done_count_r <= done_count_next_s;
            aborted_r    <= aborted_next_s;
            overflow_r   <= overflow_next_s;
        end
    end

    hit_row_unpacker u_unpacker (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush_s),
        .load         (load_s),
        .load_row     (him_rd_data),
        .load_count   (load_n_s),
        .out_ready    (out_ready),
        .out_valid    (beat_valid_s),
        .out_hit_info (out_hit_info),
        .out_last     (beat_last_s)
    );

    assign out_valid      = beat_valid_s;
    assign out_last       = beat_last_s;
    assign hnm_addr       = hnm_addr_r;
    assign hcm_addr       = hcm_addr_r;
    assign him_addr       = him_addr_r;
    assign query_done     = done_r;
    assign query_count    = done_count_r;
    assign query_aborted  = aborted_r;
    assign query_overflow = overflow_r;

endmodule

// File: tb/tb_hit_retrieval_reader.sv
// Directed bench for hit_retrieval_reader with behavioural 1-cycle-latency RAM models.
module tb_hit_retrieval_reader;
    import hit_storage_pkg::*;

    logic clock = 1'b0;
    logic reset, clear_memory, storage_ready, query_valid, query_ready;
    logic [SSID_BITS-1:0]      query_ssid;
    logic [HNM_ROW_BITS-1:0]   hnm_addr;
    logic [NCOLS_HNM-1:0]      hnm_rd_data;
    logic [SSID_BITS-1:0]      hcm_addr;
    logic [HCM_WORD_BITS-1:0]  hcm_rd_data;
    logic [HIM_ADDR_BITS-1:0]  him_addr;
    logic [HIM_WORD_BITS-1:0]  him_rd_data;
    logic out_valid, out_ready, out_last, query_done, query_overflow, query_aborted;
    logic [HIT_INFO_BITS-1:0]  out_hit_info;
    logic [HIT_COUNT_BITS-1:0] query_count;

    logic [NCOLS_HNM-1:0]     hnm_mem [0:(2**HNM_ROW_BITS)-1];
    logic [HCM_WORD_BITS-1:0] hcm_mem [0:(2**SSID_BITS)-1];
    logic [HIM_WORD_BITS-1:0] him_mem [0:(2**HIM_ADDR_BITS)-1];

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    // RAM models: synchronous read, one cycle latency
    always_ff @(posedge clock) begin
        hnm_rd_data <= hnm_mem[hnm_addr];
        hcm_rd_data <= hcm_mem[hcm_addr];
        him_rd_data <= him_mem[him_addr];
    end

    hit_retrieval_reader dut (
        .clock(clock), .reset(reset), .clear_memory(clear_memory), .storage_ready(storage_ready),
        .query_valid(query_valid), .query_ready(query_ready), .query_ssid(query_ssid),
        .hnm_addr(hnm_addr), .hnm_rd_data(hnm_rd_data), .hcm_addr(hcm_addr), .hcm_rd_data(hcm_rd_data),
        .him_addr(him_addr), .him_rd_data(him_rd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_hit_info(out_hit_info), .out_last(out_last), .query_done(query_done),
        .query_count(query_count), .query_overflow(query_overflow), .query_aborted(query_aborted)
    );

    task automatic step();
        @(negedge clock);
    endtask

    // Present a query for one edge; returns at the negedge after the accept edge
    task automatic issue(input logic [SSID_BITS-1:0] ssid);
        query_valid = 1'b1;
        query_ssid  = ssid;
        step();
        query_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; clear_memory = 1'b0; storage_ready = 1'b1; query_valid = 1'b0;
        out_ready = 1'b0; query_ssid = 10'h000;
        step(); step();
        checks++; if ({out_valid, out_last, query_done, query_aborted, query_overflow, query_count,
                       out_hit_info, hnm_addr, hcm_addr, him_addr} !== 39'd0) begin
            errors++; $display("FAIL reset_outputs: valid=%b last=%b done=%b cnt=%0d hnm=%h hcm=%h him=%h want all 0",
                               out_valid, out_last, query_done, query_count, hnm_addr, hcm_addr, him_addr); end
        checks++; if (query_ready !== 1'b1) begin errors++; $display("FAIL reset_qready: got %b want 1", query_ready); end
        storage_ready = 1'b0; #1;
        checks++; if (query_ready !== 1'b0) begin errors++; $display("FAIL reset_qready_nostore: got %b want 0", query_ready); end
        storage_ready = 1'b1; reset = 1'b0;
        step();
    endtask

    task automatic test_hit();
        out_ready = 1'b1;
        issue(10'h064);
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hit_e1_valid: got %b want 0", out_valid); end
        step();
        checks++; if ({query_done, out_valid} !== 2'b00) begin errors++; $display("FAIL hit_e2: done,valid=%b want 00", {query_done, out_valid}); end
        step();
        checks++; if (out_valid !== 1'b0 || him_addr !== 8'h05) begin errors++; $display("FAIL hit_e3: valid=%b him=%h want 0/05", out_valid, him_addr); end
        step();
        checks++; if (out_valid !== 1'b1 || out_hit_info !== 8'hB7 || out_last !== 1'b0) begin
            errors++; $display("FAIL hit_beat0: valid=%b info=%h last=%b want 1/b7/0", out_valid, out_hit_info, out_last); end
        step();
        checks++; if (out_valid !== 1'b1 || out_hit_info !== 8'hA2 || out_last !== 1'b1 || query_done !== 1'b0) begin
            errors++; $display("FAIL hit_beat1: valid=%b info=%h last=%b done=%b want 1/a2/1/0", out_valid, out_hit_info, out_last, query_done); end
        step();
        checks++; if ({out_valid, query_done, query_aborted, query_overflow} !== 4'b0100 || query_count !== 3'd2) begin
            errors++; $display("FAIL hit_done: valid,done,abort,ovf=%b cnt=%0d want 0100/2", {out_valid, query_done, query_aborted, query_overflow}, query_count); end
        step();
        checks++; if (query_done !== 1'b0) begin errors++; $display("FAIL hit_done_pulse: got %b want 0", query_done); end
    endtask

    task automatic test_miss();
        out_ready = 1'b1;
        issue(10'h065);
        step();
        checks++; if (query_done !== 1'b0) begin errors++; $display("FAIL miss_e1_done: got %b want 0", query_done); end
        step();
        checks++; if (query_done !== 1'b1 || query_count !== 3'd0 || out_valid !== 1'b0 || query_aborted !== 1'b0) begin
            errors++; $display("FAIL miss_done: done=%b cnt=%0d valid=%b abort=%b want 1/0/0/0", query_done, query_count, out_valid, query_aborted); end
        step();
        checks++; if (query_done !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL miss_after: done=%b valid=%b want 0/0", query_done, out_valid); end
    endtask

    task automatic test_stall();
        int hs;
        hs = 0;
        out_ready = 1'b0;
        issue(10'h064);
        step(); step(); step(); step();
        checks++; if (out_valid !== 1'b1 || out_hit_info !== 8'hB7 || out_last !== 1'b0) begin
            errors++; $display("FAIL stall_beat0: valid=%b info=%h last=%b want 1/b7/0", out_valid, out_hit_info, out_last); end
        out_ready = 1'b1; if (out_valid) hs++;
        step();
        checks++; if (out_valid !== 1'b1 || out_hit_info !== 8'hA2 || out_last !== 1'b1) begin
            errors++; $display("FAIL stall_beat1: valid=%b info=%h last=%b want 1/a2/1", out_valid, out_hit_info, out_last); end
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (out_valid !== 1'b1 || out_hit_info !== 8'hA2 || out_last !== 1'b1 || query_done !== 1'b0) begin
                errors++; $display("FAIL stall_hold%0d: valid=%b info=%h last=%b done=%b want 1/a2/1/0", i, out_valid, out_hit_info, out_last, query_done); end
        end
        out_ready = 1'b1; if (out_valid) hs++;
        step();
        checks++; if (out_valid !== 1'b0 || query_done !== 1'b1 || query_count !== 3'd2) begin
            errors++; $display("FAIL stall_done: valid=%b done=%b cnt=%0d want 0/1/2", out_valid, query_done, query_count); end
        checks++; if (hs !== 2) begin errors++; $display("FAIL stall_handshakes: got %0d want 2", hs); end
    endtask

    task automatic test_overflow();
        logic [HIT_INFO_BITS-1:0] exp_beats [4];
        exp_beats = '{8'h44, 8'h33, 8'h22, 8'h11};
        out_ready = 1'b1;
        issue(10'h1A3);
        step(); step(); step(); step();
        checks++; if (query_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", query_overflow); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1 || out_hit_info !== exp_beats[i] || out_last !== (i == 3)) begin
                errors++; $display("FAIL ovf_beat%0d: valid=%b info=%h last=%b want 1/%h/%b", i, out_valid, out_hit_info, out_last, exp_beats[i], (i == 3)); end
            step();
        end
        checks++; if (out_valid !== 1'b0 || query_done !== 1'b1 || query_count !== 3'd6 || query_overflow !== 1'b0) begin
            errors++; $display("FAIL ovf_done: valid=%b done=%b cnt=%0d ovf=%b want 0/1/6/0", out_valid, query_done, query_count, query_overflow); end
    endtask

    task automatic test_abort();
        out_ready = 1'b1;
        issue(10'h064);
        step(); step(); step(); step();
        checks++; if (out_hit_info !== 8'hB7) begin errors++; $display("FAIL abort_beat0: got %h want b7", out_hit_info); end
        step();
        clear_memory = 1'b1; out_ready = 1'b0;
        step();
        checks++; if ({out_valid, query_done, query_aborted} !== 3'b011 || query_count !== 3'd0) begin
            errors++; $display("FAIL abort_pulse: valid,done,abort=%b cnt=%0d want 011/0", {out_valid, query_done, query_aborted}, query_count); end
        checks++; if (query_ready !== 1'b0) begin errors++; $display("FAIL abort_qready_clear: got %b want 0", query_ready); end
        clear_memory = 1'b0; #1;
        checks++; if (query_ready !== 1'b1) begin errors++; $display("FAIL abort_qready_back: got %b want 1", query_ready); end
        step();
        checks++; if ({out_valid, query_done, query_aborted} !== 3'b000) begin
            errors++; $display("FAIL abort_after: valid,done,abort=%b want 000", {out_valid, query_done, query_aborted}); end
        clear_memory = 1'b1;
        step();
        clear_memory = 1'b0;
        checks++; if (query_done !== 1'b0 || query_aborted !== 1'b0) begin
            errors++; $display("FAIL idle_clear: done=%b abort=%b want 0/0", query_done, query_aborted); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        issue(10'h065);
        step(); step();
        checks++; if (query_done !== 1'b1 || query_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_ready: done=%b qready=%b want 1/1", query_done, query_ready); end
        issue(10'h064);
        step(); step(); step(); step();
        checks++; if (out_valid !== 1'b1 || out_hit_info !== 8'hB7) begin
            errors++; $display("FAIL b2b_beat0: valid=%b info=%h want 1/b7", out_valid, out_hit_info); end
        step(); step();
        checks++; if (query_done !== 1'b1 || query_count !== 3'd2) begin
            errors++; $display("FAIL b2b_done: done=%b cnt=%0d want 1/2", query_done, query_count); end
    endtask

    task automatic test_gate_and_reset();
        out_ready = 1'b0; storage_ready = 1'b0;
        query_valid = 1'b1; query_ssid = 10'h1A3; #1;
        checks++; if (query_ready !== 1'b0) begin errors++; $display("FAIL gate_qready: got %b want 0", query_ready); end
        step();
        checks++; if (hnm_addr !== 5'd3 || hcm_addr !== 10'h064) begin
            errors++; $display("FAIL gate_addr_hold: hnm=%h hcm=%h want 03/064", hnm_addr, hcm_addr); end
        storage_ready = 1'b1; #1;
        checks++; if (query_ready !== 1'b1) begin errors++; $display("FAIL gate_qready_up: got %b want 1", query_ready); end
        step();
        query_valid = 1'b0;
        checks++; if (hnm_addr !== 5'd13 || hcm_addr !== 10'h1A3) begin
            errors++; $display("FAIL gate_accept: hnm=%h hcm=%h want 0d/1a3", hnm_addr, hcm_addr); end
        step(); step();
        checks++; if (him_addr !== 8'h09) begin errors++; $display("FAIL gate_him: got %h want 09", him_addr); end
        reset = 1'b1;
        step();
        checks++; if ({out_valid, out_last, query_done, query_aborted, query_overflow, query_count,
                       out_hit_info, hnm_addr, hcm_addr, him_addr} !== 39'd0 || query_ready !== 1'b1) begin
            errors++; $display("FAIL midreset: valid=%b done=%b hnm=%h hcm=%h him=%h qready=%b want zeros/qready 1",
                               out_valid, query_done, hnm_addr, hcm_addr, him_addr, query_ready); end
        reset = 1'b0;
        step(); step(); step();
        checks++; if (out_valid !== 1'b0 || query_done !== 1'b0) begin
            errors++; $display("FAIL midreset_quiet: valid=%b done=%b want 0/0", out_valid, query_done); end
    endtask

    initial begin
        for (int i = 0; i < 2**HNM_ROW_BITS; i++) hnm_mem[i] = 32'h0;
        for (int i = 0; i < 2**SSID_BITS; i++) hcm_mem[i] = 11'h0;
        for (int i = 0; i < 2**HIM_ADDR_BITS; i++) him_mem[i] = 32'h0;
        hnm_mem[3]      = 32'h0000_0010;
        hcm_mem[10'h064] = {8'h05, 3'd2};
        him_mem[5]      = 32'h0000_B7A2;
        hnm_mem[13]     = 32'h0000_0008;
        hcm_mem[10'h1A3] = {8'h09, 3'd6};
        him_mem[9]      = 32'h4433_2211;

        test_reset();
        test_hit();
        test_miss();
        test_stall();
        test_overflow();
        test_abort();
        test_back_to_back();
        test_gate_and_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
